pio_ahb2apb: RTL and testbench

- AHB-Lite slave to APB master bridge.
- Sits directly upstream of the PIO APB integration wrapper and drives its PADDR/PSEL/PENABLE/PWRITE/PSTRB/PPROT/PWDATA/APBACTIVE inputs.
- Consumes PRDATA/PREADY/PSLVERR and converts them into AHB-Lite data-phase responses.
- One outstanding transfer; address phase of the next transfer may overlap the final data-phase cycle of the current one.

---
 rtl/pio_ahb2apb_pkg.sv | 44 ++++
 rtl/pio_ahb2apb.sv | 173 +++++++++++++++++
 tb/tb_pio_ahb2apb.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_ahb2apb_pkg.sv
// Shared types for the AHB-Lite to APB bridge: FSM states, AHB encodings, strobe helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package pio_ahb2apb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WLATCH,
        SETUP,
        ACCESS,
        DONE,
        ERR1,
        ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    function automatic logic [3:0] strb_gen(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: return 4'b0001 << addr_lo;
            HSIZE_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
            HSIZE_WORD: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    // Only naturally aligned byte/half/word transfers may reach APB.
    function automatic logic size_ok(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: return 1'b1;
            HSIZE_HALF: return ~addr_lo[0];
            HSIZE_WORD: return (addr_lo == 2'b00);
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pio_ahb2apb.sv
// AHB-Lite slave to APB master bridge, one outstanding transfer; PIO_AHB2APB_TIMEOUT_EN adds an ACCESS watchdog.
// Latency: read 3 / write 4 data-phase cycles plus one per PREADY-low cycle; bad size/alignment 2-cycle ERROR.
// Backpressure: HREADYOUT low from accept until DONE/ERR2; PREADY low stretches ACCESS.
module pio_ahb2apb
    import pio_ahb2apb_pkg::*;
#(
    parameter int AW             = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [3:0]    HPROT,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic [AW-1:0] PADDR,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [3:0]    PSTRB,
    output logic [2:0]    PPROT,
    output logic [31:0]   PWDATA,
    output logic          APBACTIVE,
    input  logic [31:0]   PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR
);

    state_t state, next_state;
    logic   trans_vld;
    logic   accept;
    logic   load;
    logic   timeout;

    always_comb begin
        trans_vld = 1'b0;
        case (HTRANS)
            HTRANS_IDLE, HTRANS_BUSY: trans_vld = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: trans_vld = 1'b1;
            default: trans_vld = 1'b0;
        endcase
    end

    assign accept = HSEL & HREADY & trans_vld;
    // A new address phase is only sampled while the bridge is presenting HREADYOUT high.
    assign load   = accept & ((state == IDLE) | (state == DONE) | (state == ERR2));

`ifdef PIO_AHB2APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] tcnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcnt <= '0;
        end else if (state == SETUP) begin
            tcnt <= '0;
        end else if (state == ACCESS) begin
            tcnt <= tcnt + CW'(1);
        end
    end

    assign timeout = (state == ACCESS) & ~PREADY & (tcnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR2: begin
                next_state = IDLE;
                if (load) begin
                    if (!size_ok(HSIZE, HADDR[1:0])) begin
                        next_state = ERR1;
                    end else if (HWRITE) begin
                        next_state = WLATCH;
                    end else begin
                        next_state = SETUP;
                    end
                end
            end
            WLATCH: next_state = SETUP;
            SETUP:  next_state = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    next_state = PSLVERR ? ERR1 : DONE;
                end else if (timeout) begin
                    next_state = ERR1;
                end
            end
            ERR1:    next_state = ERR2;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        APBACTIVE = 1'b0;
        case (state)
            WLATCH: begin
                HREADYOUT = 1'b0;
                APBACTIVE = 1'b1;
            end
            SETUP: begin
                HREADYOUT = 1'b0;
                PSEL      = 1'b1;
                APBACTIVE = 1'b1;
            end
            ACCESS: begin
                HREADYOUT = 1'b0;
                PSEL      = 1'b1;
                PENABLE   = 1'b1;
                APBACTIVE = 1'b1;
            end
            DONE: APBACTIVE = 1'b1;
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ERR2: HRESP = 1'b1;
            default: ;
        endcase
    end

    // APB request fields are captured at accept and held until the next accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PSTRB  <= 4'b0000;
            PPROT  <= 3'b000;
            PWDATA <= '0;
            HRDATA <= '0;
        end else begin
            if (load) begin
                PADDR  <= HADDR[AW-1:0];
                PWRITE <= HWRITE;
                PSTRB  <= HWRITE ? strb_gen(HSIZE, HADDR[1:0]) : 4'b0000;
                PPROT  <= {~HPROT[0], 1'b0, HPROT[1]};
            end
            if (state == WLATCH) begin
                PWDATA <= HWDATA;
            end
            if ((state == ACCESS) && PREADY && !PSLVERR && !PWRITE) begin
                HRDATA <= PRDATA;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{HADDR[31:AW], HPROT[3:2]};

endmodule

// File: tb/tb_pio_ahb2apb.sv
// Bench for pio_ahb2apb: directed table, reset/timeout sequences and randomized transfers vs a transaction model.
module tb_pio_ahb2apb;

    logic        clk, resetn;
    logic        HSEL, HWRITE, HREADYOUT, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    wire         HREADY;
    logic [11:0] PADDR;
    logic        PSEL, PENABLE, PWRITE, APBACTIVE;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    assign HREADY = HREADYOUT;

    pio_ahb2apb #(.AW(12), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .resetn(resetn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PSTRB(PSTRB), .PPROT(PPROT), .PWDATA(PWDATA),
        .APBACTIVE(APBACTIVE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic [31:0] wdata;
        int          waits;
        bit          err;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [3:0]  exp_strb;
        bit          exp_apb;
    } xfer_t;

    typedef struct {
        logic [11:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] wdata;
        bit          stable;
    } apb_t;

    typedef struct {
        int waits;
        bit err;
    } cfg_t;

    xfer_t       xf[128];
    xfer_t       tbl[13];
    logic [1:0]  act_resp[128];
    logic [31:0] act_rdata[128];
    int          act_lat[128];
    apb_t        mon_q[$];
    cfg_t        cfg_q[$];
    logic [31:0] smem[16];
    logic [31:0] rmem[16];
    int          n_pass, n_total;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // APB slave: per-transfer wait/error config, byte-strobed memory, completion monitor.
    initial begin : apb_slave
        int          sl_wait;
        bit          sl_err;
        cfg_t        c;
        logic [51:0] snap;
        bit          stable;
        apb_t        r;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
        sl_wait = 0; sl_err = 1'b0; snap = '0; stable = 1'b1;
        forever begin
            @(negedge clk);
            if (!resetn || !PSEL) begin
                PREADY = 1'b0; PSLVERR = 1'b0;
            end else if (!PENABLE) begin
                c = '{0, 1'b0};
                if (cfg_q.size() != 0) c = cfg_q.pop_front();
                sl_wait = c.waits; sl_err = c.err;
                snap = {PADDR, PWRITE, PSTRB, PPROT, PWDATA};
                stable = 1'b1;
                PREADY = 1'b0; PSLVERR = 1'b0;
            end else begin
                if ({PADDR, PWRITE, PSTRB, PPROT, PWDATA} != snap) stable = 1'b0;
                if (sl_wait > 0) begin
                    sl_wait--;
                    PREADY = 1'b0;
                end else begin
                    PREADY = 1'b1; PSLVERR = sl_err;
                    PRDATA = smem[PADDR[5:2]];
                    if (PWRITE && !sl_err)
                        for (int b = 0; b < 4; b++)
                            if (PSTRB[b]) smem[PADDR[5:2]][8*b +: 8] = PWDATA[8*b +: 8];
                    r = '{PADDR, PWRITE, PSTRB, PPROT, PWDATA, stable};
                    mon_q.push_back(r);
                end
            end
        end
    end

    // Transaction-level reference: legality, response, latency, strobes and a byte memory.
    task automatic model(inout xfer_t x);
        int bytes, lo;
        bit legal;
        bytes = 1 << x.size;
        lo = int'(x.addr[1:0]);
        legal = (x.size <= 2) && ((x.addr % bytes) == 0);
        x.exp_apb = legal;
        x.exp_resp = (!legal || x.err) ? 2'b11 : 2'b00;
        x.exp_lat = !legal ? 2 : (x.wr ? 1 : 0) + 1 + (x.waits + 1) + (x.err ? 2 : 1);
        x.exp_strb = 4'b0000;
        x.exp_rdata = rmem[x.addr[5:2]];
        if (legal && x.wr) begin
            for (int b = 0; b < bytes; b++) begin
                x.exp_strb[lo + b] = 1'b1;
                if (!x.err) rmem[x.addr[5:2]][8*(lo+b) +: 8] = x.wdata[8*(lo+b) +: 8];
            end
        end
    endtask

    task automatic idle_drive();
        case ($urandom_range(0, 3))
            0: begin HSEL = 1'b0; HTRANS = 2'b10; end
            1: begin HSEL = 1'b1; HTRANS = 2'b00; end
            2: begin HSEL = 1'b1; HTRANS = 2'b01; end
            default: begin HSEL = 1'b0; HTRANS = 2'b00; end
        endcase
        HADDR = $urandom;
        HWRITE = 1'(($urandom_range(0, 1)));
    endtask

    // Pipelined AHB master: a new address phase is offered whenever HREADY is high.
    task automatic run(input int n, input bit gaps);
        int ai, di, cyc;
        int acc_c[128];
        logic prev_hresp;
        ai = 0; di = -1; cyc = 0;
        prev_hresp = HRESP;
        while ((ai < n || di >= 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            HWDATA = (di >= 0) ? xf[di].wdata : 32'h0;
            if (HREADYOUT) begin
                if (di >= 0) begin
                    act_resp[di] = {prev_hresp, HRESP};
                    act_rdata[di] = HRDATA;
                    act_lat[di] = cyc - acc_c[di];
                    di = -1;
                end
                if (ai < n && (!gaps || $urandom_range(0, 3) != 0)) begin
                    HSEL = 1'b1;
                    HTRANS = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
                    HADDR = xf[ai].addr; HWRITE = xf[ai].wr;
                    HSIZE = xf[ai].size; HPROT = xf[ai].prot;
                    acc_c[ai] = cyc; di = ai; ai++;
                end else idle_drive();
            end else idle_drive();
            prev_hresp = HRESP;
        end
        if (cyc >= 4000) begin
            n_total++;
            $display("FAIL run_timeout: got %0d cycles required fewer than 4000", cyc);
        end
        @(negedge clk);
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    task automatic compare(input int n);
        apb_t m;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("resp[%0d]", i), 32'(act_resp[i]), 32'(xf[i].exp_resp));
            chk($sformatf("latency[%0d]", i), act_lat[i], xf[i].exp_lat);
            if (!xf[i].wr && xf[i].exp_resp == 2'b00)
                chk($sformatf("hrdata[%0d]", i), act_rdata[i], xf[i].exp_rdata);
            if (xf[i].exp_apb) begin
                if (mon_q.size() == 0) begin
                    n_total++;
                    $display("FAIL apb_missing[%0d]: got no APB transfer required one", i);
                end else begin
                    m = mon_q.pop_front();
                    chk($sformatf("paddr[%0d]", i), 32'(m.addr), 32'(xf[i].addr[11:0]));
                    chk($sformatf("pwrite[%0d]", i), 32'(m.wr), 32'(xf[i].wr));
                    chk($sformatf("pstrb[%0d]", i), 32'(m.strb), 32'(xf[i].exp_strb));
                    chk($sformatf("pprot[%0d]", i), 32'(m.prot),
                        32'({~xf[i].prot[0], 1'b0, xf[i].prot[1]}));
                    if (xf[i].wr) chk($sformatf("pwdata[%0d]", i), m.wdata, xf[i].wdata);
                    chk($sformatf("apb_stable[%0d]", i), 32'(m.stable), 32'd1);
                end
            end
        end
        chk("apb_extra", mon_q.size(), 0);
        mon_q.delete();
    endtask

    task automatic push_cfg(input int n);
        for (int i = 0; i < n; i++)
            if (xf[i].exp_apb) cfg_q.push_back('{xf[i].waits, xf[i].err});
    endtask

    function automatic xfer_t mk(bit wr, logic [31:0] a, logic [2:0] sz, logic [31:0] wd, int w,
                                 bit e, logic [1:0] er, logic [31:0] erd, int el, logic [3:0] es, bit ea);
        xfer_t x;
        x = '{wr, a, sz, 4'($urandom_range(0, 15)), wd, w, e, er, erd, el, es, ea};
        return x;
    endfunction

    initial begin : main
        xfer_t t;
        int    k;
        n_pass = 0; n_total = 0;
        for (int i = 0; i < 16; i++) begin smem[i] = 32'h0; rmem[i] = 32'h0; end
        HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
        HPROT = 4'h0; HWDATA = 32'h0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_apbactive", 32'(APBACTIVE), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'h0);
        chk("rst_pstrb", 32'(PSTRB), 32'h0);
        chk("rst_pprot", 32'(PPROT), 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // wr addr size wdata waits err | resp rdata lat strb apb
        tbl[0]  = mk(1, 32'h0000_0104, 3'd2, 32'hDEAD_BEEF, 0, 0, 2'b00, 32'h0,         4, 4'hF, 1);
        tbl[1]  = mk(0, 32'h0000_0104, 3'd2, 32'h0,         0, 0, 2'b00, 32'hDEAD_BEEF, 3, 4'h0, 1);
        tbl[2]  = mk(1, 32'h0000_0003, 3'd0, 32'hAA00_0000, 0, 0, 2'b00, 32'h0,         4, 4'h8, 1);
        tbl[3]  = mk(0, 32'h0000_0000, 3'd2, 32'h0,         0, 0, 2'b00, 32'hAA00_0000, 3, 4'h0, 1);
        tbl[4]  = mk(0, 32'h0000_0008, 3'd2, 32'h0,         0, 1, 2'b11, 32'h0,         4, 4'h0, 1);
        tbl[5]  = mk(0, 32'h0000_0010, 3'd3, 32'h0,         0, 0, 2'b11, 32'h0,         2, 4'h0, 0);
        tbl[6]  = mk(1, 32'h0000_0001, 3'd1, 32'h5555_5555, 0, 0, 2'b11, 32'h0,         2, 4'h0, 0);
        tbl[7]  = mk(1, 32'h8000_0106, 3'd1, 32'h1234_0000, 2, 0, 2'b00, 32'h0,         6, 4'hC, 1);
        tbl[8]  = mk(0, 32'h0000_0104, 3'd2, 32'h0,         0, 0, 2'b00, 32'h1234_BEEF, 3, 4'h0, 1);
        tbl[9]  = mk(1, 32'h0000_0105, 3'd0, 32'h0000_5500, 0, 0, 2'b00, 32'h0,         4, 4'h2, 1);
        tbl[10] = mk(0, 32'hFFFF_F104, 3'd2, 32'h0,         1, 0, 2'b00, 32'h1234_55EF, 4, 4'h0, 1);
        tbl[11] = mk(1, 32'h0000_0008, 3'd2, 32'h1111_1111, 1, 1, 2'b11, 32'h0,         6, 4'hF, 1);
        tbl[12] = mk(0, 32'h0000_0008, 3'd2, 32'h0,         0, 0, 2'b00, 32'h0,         3, 4'h0, 1);
        for (int i = 0; i < 13; i++) begin
            xf[i] = tbl[i];
            t = tbl[i];
            model(t);
        end
        push_cfg(13);
        run(13, 1'b0);
        compare(13);

        // Reset in the middle of a stalled ACCESS abandons the transfer.
        cfg_q.push_back('{5, 1'b0});
        @(negedge clk);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0104; HWRITE = 1'b0; HSIZE = 3'd2;
        @(negedge clk);
        HSEL = 1'b0; HTRANS = 2'b00;
        k = 0;
        while (!PENABLE && k < 10) begin @(negedge clk); k++; end
        chk("reach_access", 32'(PENABLE), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_psel", 32'(PSEL), 32'd0);
        chk("midrst_penable", 32'(PENABLE), 32'd0);
        chk("midrst_apbactive", 32'(APBACTIVE), 32'd0);
        chk("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        cfg_q.delete();
        mon_q.delete();
        @(negedge clk);
        xf[0] = mk(0, 32'h0000_0104, 3'd2, 32'h0, 0, 0, 2'b00, 32'h0, 0, 4'h0, 0);
        model(xf[0]);
        push_cfg(1);
        run(1, 1'b0);
        compare(1);

`ifdef PIO_AHB2APB_TIMEOUT_EN
        xf[0] = mk(0, 32'h0000_0020, 3'd2, 32'h0, 1000, 0, 2'b11, 32'h0, 11, 4'h0, 0);
        cfg_q.push_back('{1000, 1'b0});
        run(1, 1'b0);
        compare(1);
        cfg_q.delete();
`endif

        for (int i = 0; i < 60; i++) begin
            t.wr = 1'($urandom_range(0, 1));
            t.size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            t.addr = $urandom;
            if ($urandom_range(0, 7) != 0 && t.size <= 3'd2)
                t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
            t.prot = 4'($urandom_range(0, 15));
            t.wdata = $urandom;
            t.waits = $urandom_range(0, 3);
            t.err = ($urandom_range(0, 7) == 0);
            model(t);
            xf[i] = t;
        end
        push_cfg(60);
        run(60, 1'b1);
        compare(60);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
